// File: rtl/hex_sb_pkg.sv
// Shared constants for the hex display bus slave: register addresses and the
// hex-to-segment lookup (segments {g,f,e,d,c,b,a}, active-low).
package hex_sb_pkg;

   localparam logic [31:0] ADDR_DIGIT0 = 32'h00;
   localparam logic [31:0] ADDR_MASK   = 32'h20;
   localparam logic [31:0] ADDR_RST    = 32'h24;
   localparam logic [31:0] ADDR_DP     = 32'h28;

   localparam logic [6:0]  SEG_BLANK   = 7'h7F;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      logic [6:0] seg;
      seg = SEG_BLANK;
      unique case (value)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_digit_decoder.sv
// Combinational hex digit to active-low 7-segment pattern.
module hex_digit_decoder
   import hex_sb_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = hex_to_seg(digit_i);
   end

endmodule

// File: rtl/hex_sb_ctrl.sv
// Bus-slave controller for an 8-digit multiplexed 7-segment display.
// Define HEX_DP_EN to add the decimal-point mask register (0x28) and hex_dp_o.
module hex_sb_ctrl
   import hex_sb_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned DIGITS   = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              write_enable_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       write_data_i,
   output logic [31:0]       read_data_o,
   output logic [6:0]        hex_led_o,
   output logic [DIGITS-1:0] hex_sel_o
`ifdef HEX_DP_EN
   ,
   output logic              hex_dp_o
`endif
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = $clog2(DIGITS);

   logic [3:0]        digit_q [DIGITS];
   logic [3:0]        digit_d [DIGITS];
   logic [DIGITS-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic [6:0]        led_q, led_d;
`ifdef HEX_DP_EN
   logic [DIGITS-1:0] dp_q, dp_d;
   logic              dp_out_q, dp_out_d;
`endif

   logic             wr, rd, aligned;
   logic             hit_digit, hit_mask, hit_rst, hit_dp;
   logic             soft_rst;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      rd_mux;
   logic [6:0]       cur_seg;

   assign wr        = req_i & write_enable_i;
   assign rd        = req_i & ~write_enable_i;
   assign aligned   = (addr_i[1:0] == 2'b00);
   // Digit registers occupy every word below the mask register.
   assign hit_digit = aligned && (addr_i >= ADDR_DIGIT0) && (addr_i < ADDR_MASK);
   assign hit_mask  = (addr_i == ADDR_MASK);
   assign hit_rst   = (addr_i == ADDR_RST);
`ifdef HEX_DP_EN
   assign hit_dp    = (addr_i == ADDR_DP);
`else
   assign hit_dp    = 1'b0;
`endif
   assign acc_idx   = addr_i[IDX_W+1:2];
   assign soft_rst  = wr && hit_rst && (write_data_i == 32'd1);

   hex_digit_decoder u_decoder (
      .digit_i (digit_q[idx_q]),
      .seg_o   (cur_seg)
   );

   always_comb begin
      rd_mux = 32'd0;
      if (hit_digit) begin
         rd_mux = {28'd0, digit_q[acc_idx]};
      end else if (hit_mask) begin
         rd_mux = 32'(mask_q);
      end
`ifdef HEX_DP_EN
      else if (hit_dp) begin
         rd_mux = 32'(dp_q);
      end
`endif
   end

   always_comb begin
      digit_d = digit_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      rdata_d = rdata_q;
      sel_d   = {DIGITS{1'b1}};
      led_d   = SEG_BLANK;
`ifdef HEX_DP_EN
      dp_d     = dp_q;
      dp_out_d = ~(dp_q[idx_q] & mask_q[idx_q]);
`endif

      if (wr && hit_digit) begin
         digit_d[acc_idx] = write_data_i[3:0];
      end
      if (wr && hit_mask) begin
         mask_d = write_data_i[DIGITS-1:0];
      end
`ifdef HEX_DP_EN
      if (wr && hit_dp) begin
         dp_d = write_data_i[DIGITS-1:0];
      end
`endif

      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end

      // Outputs track the index held this cycle, so they lag idx by one clock.
      if (mask_q[idx_q]) begin
         sel_d = ~(DIGITS'(1) << idx_q);
         led_d = cur_seg;
      end

      if (soft_rst) begin
         digit_d = '{default: '0};
         mask_d  = '0;
         cnt_d   = '0;
         idx_d   = '0;
         sel_d   = {DIGITS{1'b1}};
         led_d   = SEG_BLANK;
`ifdef HEX_DP_EN
         dp_d     = '0;
         dp_out_d = 1'b1;
`endif
      end

      // Soft reset deliberately leaves read data untouched.
      if (rd) begin
         rdata_d = rd_mux;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         digit_q <= '{default: '0};
         mask_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         rdata_q <= '0;
         sel_q   <= {DIGITS{1'b1}};
         led_q   <= SEG_BLANK;
`ifdef HEX_DP_EN
         dp_q     <= '0;
         dp_out_q <= 1'b1;
`endif
      end else begin
         digit_q <= digit_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         sel_q   <= sel_d;
         led_q   <= led_d;
`ifdef HEX_DP_EN
         dp_q     <= dp_d;
         dp_out_q <= dp_out_d;
`endif
      end
   end

   assign read_data_o = rdata_q;
   assign hex_sel_o   = sel_q;
   assign hex_led_o   = led_q;
`ifdef HEX_DP_EN
   assign hex_dp_o    = dp_out_q;
`endif

endmodule

// File: doc/hex_sb_ctrl.md
Name: hex_sb_ctrl

Overview:
Memory-mapped output peripheral on the system bus that drives the board's 8-digit multiplexed 7-segment display.
- The CPU writes per-digit hex values and a digit-enable mask.
- The block time-multiplexes the digits with a free-running scan counter.
- It is the output-direction counterpart of the switch input controller and uses the same bus-slave handshake.

Parameters:
SCAN_DIV, 100000, clk_i cycles each digit stays lit (≥2)
DIGITS, 8, number of digits (fixed 8 in this revision)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-low
req_i  in  1  bus request
write_enable_i  in  1  1=write, 0=read
addr_i  in  32  byte address, block-relative
write_data_i  in  32  write data
read_data_o  out  32  read data, registered
hex_led_o  out  7  segments {g,f,e,d,c,b,a}, active-low
hex_sel_o  out  8  digit anodes, active-low, one-hot-zero

Behaviour:
Register map (word addresses):
- 0x00–0x1C: digit0..digit7, 4 bits each; write uses write_data_i[3:0], upper bits ignored.
- 0x20: enable mask, 8 bits, bit n enables digit n.
- 0x24: soft reset, write-only; writing value 1 resets all registers; other values are ignored.

Bus:
- Access occurs when req_i=1.
- Write: register updates on the clk_i edge where req_i & write_enable_i; no wait states.
- Read: read_data_o updates on the edge where req_i & ~write_enable_i, i.e. one-cycle latency. Value is the zero-extended register; 0x24 and unmapped addresses return 0.
- read_data_o holds its value when there is no read.
- Writes to unmapped addresses or misaligned addresses (addr_i[1:0]≠0) are ignored.

Reset (rst_i=0, or soft reset):
- Digits = 0, mask = 0x00, scan counter = 0, digit index = 0.
- hex_sel_o = 8'hFF, hex_led_o = 7'h7F.
- read_data_o = 0 on rst_i only; soft reset leaves read_data_o unchanged.
- Reset mid-scan restarts scanning from digit 0 on the next cycle.

Scan:
- cnt counts 0..SCAN_DIV-1 and wraps.
- On wrap, idx increments 0..7 and wraps 7→0.
- Outputs are registered and reflect the current idx one cycle after idx changes.
- If mask[idx]=1: hex_sel_o = ~(8'b1<<idx) and hex_led_o = seg(digit[idx]).
- If mask[idx]=0: hex_sel_o = 8'hFF and hex_led_o = 7'h7F.

Segment decode (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Simultaneous events:
- A write to the digit currently displayed takes effect on output at the next output register update (≤1 cycle later, since outputs re-evaluate every cycle).
- Soft reset has priority over scan.
- rst_i has priority over everything.

Optional Feature:
HEX_DP_EN
- Defined:
  - Adds port hex_dp_o (1 bit, active-low decimal point).
  - Adds register 0x28: 8-bit DP mask, readable and writable, reset 0x00.
  - hex_dp_o = ~(dp[idx] & mask[idx]), registered with the other outputs.
- Undefined:
  - No port.
  - 0x28 behaves as unmapped: reads 0, writes ignored.

Decomposition:
- Package hex_sb_pkg:
  - Address constants: ADDR_DIGIT0, ADDR_MASK = 32'h20, ADDR_RST = 32'h24, ADDR_DP = 32'h28.
  - SEG_BLANK = 7'h7F.
  - Function or constant array for the hex→segment table.
- One sub-module, hex_digit_decoder: 4-bit in, 7-bit active-low segment out, purely combinational; instantiated once on the muxed digit.

Test Plan (SCAN_DIV=4):
1. Reset: hold rst_i=0 for 3 cycles → hex_sel_o=FF, hex_led_o=7F, read_data_o=0; read 0x20 returns 0.
2. Write digit0=0x5, digit3=0xF, mask=0x09, then observe 32 cycles:
   - hex_sel_o=FE with hex_led_o=0010010 for 4 cycles.
   - FF/7F for the digit1 and digit2 slots.
   - F7 with 0001110 for the digit3 slot.
   - Pattern repeats with period 32.
3. Write 0xABCD_0007 to 0x04 and read 0x04 → read_data_o=0x00000007 one cycle after the read request. Read 0x30 → 0.
4. Write mask=0xFF, then 1 to 0x24 mid-scan → next cycle all registers 0 and idx=0; outputs FF/7F. Writing 2 to 0x24 has no effect.
5. Write to 0x40 and a misaligned write to 0x21 → no register changes; mask reads back unchanged.
6. With HEX_DP_EN: write DP=0x01, mask=0x01 → hex_dp_o=0 only during the digit0 slot, otherwise 1; read 0x28 returns 1. Without the macro, read 0x28 returns 0.
